// File: rtl/cnn_result_streamer_if.sv
// Result stream bundle between the CNN result drain and the downstream pooling/DMA stage.
// Latency: none, wires only.
// Backpressure: master holds all fields while out_valid && !out_ready. sat_flag exists only with RESULT_SAT_EN.
interface cnn_result_streamer_if #(
    parameter int OUT_DW = 16,
    parameter int IDX_W  = 6
);
    logic [OUT_DW-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic [IDX_W-1:0]  out_idx;
    logic              out_row_end;
    logic              out_last;
`ifdef RESULT_SAT_EN
    logic              sat_flag;
`endif

    modport master (
        input  out_ready,
        output out_data, out_valid, out_idx, out_row_end, out_last
`ifdef RESULT_SAT_EN
        , sat_flag
`endif
    );

    modport slave (
        output out_ready,
        input  out_data, out_valid, out_idx, out_row_end, out_last
`ifdef RESULT_SAT_EN
        , sat_flag
`endif
    );
endinterface

// File: rtl/cnn_result_streamer.sv
// Drains the conv engine result array in raster order as a valid/ready word stream.
// Latency: first word one cycle after a done rising edge is sampled, then 1 word/cycle.
// Backpressure: output register holds while out_valid && !out_ready; nothing is dropped.
// Optional macro RESULT_SAT_EN: signed clamp to OUT_DW bits plus a per-word sat_flag.
module cnn_result_streamer #(
    parameter  int IMG_W  = 8,
    parameter  int IMG_H  = 8,
    parameter  int DATA_W = 32,
    parameter  int OUT_DW = 16,
    localparam int OUT_W  = IMG_W - 2,
    localparam int OUT_H  = IMG_H - 2,
    localparam int N      = OUT_W * OUT_H,
    localparam int IDX_W  = (N > 1) ? $clog2(N) : 1,
    localparam int PTR_W  = $clog2(N + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     eng_done,
    input  logic signed [DATA_W-1:0] res_ram [N],
    output logic                     busy,
    output logic                     overrun,
    output logic [7:0]               frame_cnt,
    cnn_result_streamer_if.master    bus
);

    typedef enum logic {ST_IDLE, ST_STREAM} state_t;

    state_t            state_q, state_d;
    logic              done_q, done_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [OUT_DW-1:0] out_data_q, out_data_d;
    logic [IDX_W-1:0]  out_idx_q, out_idx_d;
    logic              out_valid_q, out_valid_d;
    logic              out_row_end_q, out_row_end_d;
    logic              out_last_q, out_last_d;
    logic              busy_q, busy_d;
    logic              overrun_q, overrun_d;
    logic [7:0]        frame_cnt_q, frame_cnt_d;

    logic              done_edge;
    logic              load_en;
    logic [IDX_W-1:0]  load_idx;

`ifdef RESULT_SAT_EN
    localparam logic signed [DATA_W-1:0] SAT_MAX =
        {{(DATA_W-OUT_DW+1){1'b0}}, {(OUT_DW-1){1'b1}}};
    localparam logic signed [DATA_W-1:0] SAT_MIN = ~SAT_MAX;

    logic sat_flag_q, sat_flag_d;

    function automatic logic [OUT_DW-1:0] conv_word(input logic signed [DATA_W-1:0] w);
        if (w > SAT_MAX)      return SAT_MAX[OUT_DW-1:0];
        else if (w < SAT_MIN) return SAT_MIN[OUT_DW-1:0];
        else                  return w[OUT_DW-1:0];
    endfunction

    function automatic logic is_sat(input logic signed [DATA_W-1:0] w);
        return (w > SAT_MAX) || (w < SAT_MIN);
    endfunction
`else
    function automatic logic [OUT_DW-1:0] conv_word(input logic signed [DATA_W-1:0] w);
        return w[OUT_DW-1:0];
    endfunction

    // Truncation drops the upper result bits on purpose; fold them so they read as consumed.
    logic unused_hi_bits;
    always_comb begin
        unused_hi_bits = 1'b0;
        for (int i = 0; i < N; i++) begin
            unused_hi_bits = unused_hi_bits ^ (^res_ram[i][DATA_W-1:OUT_DW]);
        end
    end
`endif

    // Next-state: edge detect, frame sequencing and output register loading.
    always_comb begin
        state_d       = state_q;
        done_d        = eng_done;
        rd_ptr_d      = rd_ptr_q;
        out_data_d    = out_data_q;
        out_idx_d     = out_idx_q;
        out_valid_d   = out_valid_q;
        out_row_end_d = out_row_end_q;
        out_last_d    = out_last_q;
        busy_d        = busy_q;
        overrun_d     = overrun_q;
        frame_cnt_d   = frame_cnt_q;
`ifdef RESULT_SAT_EN
        sat_flag_d    = sat_flag_q;
`endif
        done_edge     = eng_done & ~done_q;
        load_en       = 1'b0;
        load_idx      = '0;

        case (state_q)
            ST_IDLE: begin
                if (done_edge) begin
                    load_en = 1'b1;
                    busy_d  = 1'b1;
                    state_d = ST_STREAM;
                end
            end
            ST_STREAM: begin
                // A new frame cannot start until this one drains, including on its final accept.
                if (done_edge) overrun_d = 1'b1;
                if (!out_valid_q || bus.out_ready) begin
                    if (out_valid_q && out_last_q) begin
                        out_valid_d = 1'b0;
                        busy_d      = 1'b0;
                        frame_cnt_d = frame_cnt_q + 8'd1;
                        state_d     = ST_IDLE;
                    end else if (int'(rd_ptr_q) < N) begin
                        load_en  = 1'b1;
                        load_idx = IDX_W'(rd_ptr_q);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (load_en) begin
            out_data_d    = conv_word(res_ram[load_idx]);
            out_idx_d     = load_idx;
            out_row_end_d = (int'(load_idx) % OUT_W) == (OUT_W - 1);
            out_last_d    = int'(load_idx) == (N - 1);
            out_valid_d   = 1'b1;
            rd_ptr_d      = PTR_W'(int'(load_idx) + 1);
`ifdef RESULT_SAT_EN
            sat_flag_d    = is_sat(res_ram[load_idx]);
`endif
        end
    end

    // State and output registers; reset discards any frame in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            done_q        <= 1'b0;
            rd_ptr_q      <= '0;
            out_data_q    <= '0;
            out_idx_q     <= '0;
            out_valid_q   <= 1'b0;
            out_row_end_q <= 1'b0;
            out_last_q    <= 1'b0;
            busy_q        <= 1'b0;
            overrun_q     <= 1'b0;
            frame_cnt_q   <= '0;
`ifdef RESULT_SAT_EN
            sat_flag_q    <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            done_q        <= done_d;
            rd_ptr_q      <= rd_ptr_d;
            out_data_q    <= out_data_d;
            out_idx_q     <= out_idx_d;
            out_valid_q   <= out_valid_d;
            out_row_end_q <= out_row_end_d;
            out_last_q    <= out_last_d;
            busy_q        <= busy_d;
            overrun_q     <= overrun_d;
            frame_cnt_q   <= frame_cnt_d;
`ifdef RESULT_SAT_EN
            sat_flag_q    <= sat_flag_d;
`endif
        end
    end

    assign bus.out_data    = out_data_q;
    assign bus.out_idx     = out_idx_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_row_end = out_row_end_q;
    assign bus.out_last    = out_last_q;
`ifdef RESULT_SAT_EN
    assign bus.sat_flag    = sat_flag_q;
`endif
    assign busy      = busy_q;
    assign overrun   = overrun_q;
    assign frame_cnt = frame_cnt_q;

endmodule
